// File: rtl/ppfifo_2_axi_stream_pkg.sv
// Shared Ping Pong FIFO definitions used by the PPFIFO stream reader and writer.
package ppfifo_2_axi_stream_pkg;

  localparam int PPFIFO_SIZE_W = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READY   = 2'd1,
    RELEASE = 2'd2
  } ppfifo_state_e;

endpackage

// File: rtl/ppfifo_2_axi_stream_axi_out_reg.sv
// Single-entry AXI stream output register: loads on a FIFO pop, holds while
// the consumer stalls, drains when the consumer accepts and nothing new arrives.
module axi_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last
);

  logic [DATA_WIDTH-1:0] data_p0;
  logic                  last_p0;
  logic                  vld_p0;

  // stage p0: output beat register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      data_p0 <= '0;
    end else if (load) begin
      vld_p0  <= 1'b1;
      last_p0 <= load_last;
      data_p0 <= load_data;
    end else if (vld_p0 && ready) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end
  end

  assign valid = vld_p0;
  assign data  = data_p0;
  assign last  = last_p0;

endmodule

// File: rtl/ppfifo_2_axi_stream.sv
// Drains Ping Pong FIFO read blocks onto an AXI stream, one packet per block,
// with TLAST on the final word of each block.
module ppfifo_2_axi_stream
  import ppfifo_2_axi_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     o_ppfifo_clk,
  input  logic                     i_ppfifo_rdy,
  output logic                     o_ppfifo_act,
  input  logic [PPFIFO_SIZE_W-1:0] i_ppfifo_size,
  output logic                     o_ppfifo_stb,
  input  logic [DATA_WIDTH-1:0]    i_ppfifo_data,
  output logic                     o_axi_valid,
  input  logic                     i_axi_ready,
  output logic [DATA_WIDTH-1:0]    o_axi_data,
  output logic [DATA_WIDTH/8-1:0]  o_axi_keep,
  output logic                     o_axi_last
);

  ppfifo_state_e            state, state_nxt;
  logic [PPFIFO_SIZE_W-1:0] r_size, size_nxt;
  logic [PPFIFO_SIZE_W-1:0] r_count, count_nxt;
  logic                     act_nxt;
  logic                     stb;
  logic                     blk_done;
  logic                     last_word;

  assign o_ppfifo_clk = clk;
  assign o_axi_keep   = '1;

  assign blk_done  = (r_count == r_size);
  assign last_word = (r_count == (r_size - PPFIFO_SIZE_W'(1)));
  // Pop only when the output register is empty or being drained this cycle.
  assign stb = (state == READY) && (r_count < r_size) &&
               (!o_axi_valid || i_axi_ready);
  assign o_ppfifo_stb = stb;

  always_comb begin
    state_nxt = state;
    size_nxt  = r_size;
    count_nxt = r_count;
    act_nxt   = o_ppfifo_act;
    unique case (state)
      IDLE: begin
        act_nxt = 1'b0;
        if (i_ppfifo_rdy && !o_ppfifo_act) begin
          act_nxt   = 1'b1;
          size_nxt  = i_ppfifo_size;
          count_nxt = '0;
          state_nxt = READY;
        end
      end
      READY: begin
        if (stb) begin
          count_nxt = r_count + PPFIFO_SIZE_W'(1);
        end
        // Leave on the final pop so the block is released without a dead cycle.
        if (blk_done || (stb && last_word)) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        act_nxt   = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        act_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      o_ppfifo_act <= 1'b0;
      r_size       <= '0;
      r_count      <= '0;
    end else begin
      state        <= state_nxt;
      o_ppfifo_act <= act_nxt;
      r_size       <= size_nxt;
      r_count      <= count_nxt;
    end
  end

  axi_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_axi_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (stb),
    .load_data(i_ppfifo_data),
    .load_last(last_word),
    .ready    (i_axi_ready),
    .valid    (o_axi_valid),
    .data     (o_axi_data),
    .last     (o_axi_last)
  );

endmodule
